// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract block accumulator.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int SAMPLE_W          = 4;
   localparam int DEFAULT_ACC_W     = 8;
   localparam int DEFAULT_BLOCK_LEN = 8;

   // 4 bits covers the full legal BLOCK_LEN range of 2..15.
   localparam int COUNT_W = 4;

   // The upstream 3-bit adder's carry becomes the sample MSB.
   function automatic logic [SAMPLE_W-1:0] sample_of(input logic c_out,
                                                    input logic [2:0] s);
      return {c_out, s};
   endfunction

endpackage

// File: rtl/acc_alu.sv
// Add/subtract datapath for the block accumulator.
// Build option: ADDSUB_ACC_SAT_EN clamps the result on overflow/underflow;
// without it the result wraps modulo 2^ACC_W. ovf_evt is identical either way.
module acc_alu
   import addsub_pkg::*;
#(
   parameter int ACC_W = DEFAULT_ACC_W
) (
   input  logic [ACC_W-1:0]    acc,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic                add,
   output logic [ACC_W-1:0]    next_acc,
   output logic                ovf_evt
);

   logic [ACC_W:0] wide;
   logic [ACC_W:0] sample_ext;

   assign sample_ext = (ACC_W+1)'(sample);

   // One extra bit catches the carry out of an add or the borrow of a subtract.
   always_comb begin
      wide = '0;
      if (add) begin
         wide = {1'b0, acc} + sample_ext;
      end else begin
         wide = {1'b0, acc} - sample_ext;
      end
   end

   assign ovf_evt = wide[ACC_W];

`ifdef ADDSUB_ACC_SAT_EN
   // Clamp to full scale on overflow and to zero on underflow.
   always_comb begin
      next_acc = wide[ACC_W-1:0];
      if (ovf_evt) begin
         next_acc = add ? {ACC_W{1'b1}} : {ACC_W{1'b0}};
      end
   end
`else
   // Plain modulo arithmetic.
   always_comb begin
      next_acc = wide[ACC_W-1:0];
   end
`endif

endmodule

// File: rtl/addsub_acc.sv
// Block accumulator: sums BLOCK_LEN add/subtract samples from an upstream
// 3-bit adder, publishes the block total on result with a one-cycle done.
// Build option: ADDSUB_ACC_SAT_EN (saturating accumulate, see acc_alu).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no block in progress; next in_valid starts a block from 0
// ACCUM | block in progress, count samples taken so far
// DONE  | one cycle after the last sample; done high, in_valid restarts
module addsub_acc
   import addsub_pkg::*;
#(
   parameter int ACC_W     = DEFAULT_ACC_W,
   parameter int BLOCK_LEN = DEFAULT_BLOCK_LEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             add,
   input  logic [2:0]       s,
   input  logic             c_out,
   input  logic             clr,
   output logic [ACC_W-1:0] acc,
   output logic [ACC_W-1:0] result,
   output logic             done,
   output logic             ovf,
   output logic             busy
);

   localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(BLOCK_LEN);

   state_t               state, state_nxt;
   logic [ACC_W-1:0]     acc_nxt, result_nxt, alu_base, next_acc;
   logic [COUNT_W-1:0]   count, count_nxt, count_inc;
   logic                 ovf_nxt, done_nxt, ovf_evt;
   logic [SAMPLE_W-1:0]  sample;

   assign sample    = sample_of(c_out, s);
   assign count_inc = count + 1'b1;

   // A new block starts from zero, so the ALU sees 0 outside ACCUM.
   assign alu_base = (state == ACCUM) ? acc : '0;

   acc_alu #(
      .ACC_W (ACC_W)
   ) u_alu (
      .acc      (alu_base),
      .sample   (sample),
      .add      (add),
      .next_acc (next_acc),
      .ovf_evt  (ovf_evt)
   );

   // Next-state and next-register values; clr overrides everything but result.
   always_comb begin
      state_nxt  = state;
      acc_nxt    = acc;
      result_nxt = result;
      count_nxt  = count;
      ovf_nxt    = ovf;
      done_nxt   = 1'b0;
      if (clr) begin
         state_nxt = IDLE;
         acc_nxt   = '0;
         count_nxt = '0;
         ovf_nxt   = 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               state_nxt = IDLE;
               if (in_valid) begin
                  acc_nxt   = next_acc;
                  count_nxt = COUNT_W'(1);
                  ovf_nxt   = ovf_evt;
                  state_nxt = ACCUM;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  acc_nxt = next_acc;
                  ovf_nxt = ovf | ovf_evt;
                  if (count_inc == LAST_COUNT) begin
                     result_nxt = next_acc;
                     done_nxt   = 1'b1;
                     count_nxt  = '0;
                     state_nxt  = DONE;
                  end else begin
                     count_nxt = count_inc;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               acc_nxt   = '0;
               count_nxt = '0;
               ovf_nxt   = 1'b0;
            end
         endcase
      end
   end

   // State and output registers; busy is registered off the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         result <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         done   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_nxt;
         acc    <= acc_nxt;
         result <= result_nxt;
         count  <= count_nxt;
         ovf    <= ovf_nxt;
         done   <= done_nxt;
         busy   <= (state_nxt == ACCUM);
      end
   end

endmodule

// File: tb/tb_addsub_acc.sv
// Directed bench for addsub_acc (8-bit instance plus a 6-bit instance for
// the overflow case). Expected values depend on ADDSUB_ACC_SAT_EN.
module tb_addsub_acc;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       add = 1'b1;
   logic [2:0] s = 3'd0;
   logic       c_out = 1'b0;
   logic       clr = 1'b0;

   logic [7:0] acc, result;
   logic       done, ovf, busy;
   logic [5:0] acc6, result6;
   logic       done6, ovf6, busy6;

   int n_chk = 0;
   int n_err = 0;

`ifdef ADDSUB_ACC_SAT_EN
   localparam int EXP_UNDER  = 0;
   localparam int EXP_RES6   = 63;
`else
   localparam int EXP_UNDER  = 253;
   localparam int EXP_RES6   = 56;
`endif

   addsub_acc #(.ACC_W(8), .BLOCK_LEN(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .add(add), .s(s),
      .c_out(c_out), .clr(clr), .acc(acc), .result(result), .done(done),
      .ovf(ovf), .busy(busy)
   );

   addsub_acc #(.ACC_W(6), .BLOCK_LEN(8)) dut6 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .add(add), .s(s),
      .c_out(c_out), .clr(clr), .acc(acc6), .result(result6), .done(done6),
      .ovf(ovf6), .busy(busy6)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_chk++;
      if (obs != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   // Apply one cycle of inputs, then sample just after the rising edge.
   task automatic step(input logic v, input logic a, input int val, input logic c);
      logic [3:0] v4;
      v4       = 4'(val);
      in_valid = v;
      add      = a;
      c_out    = v4[3];
      s        = v4[2:0];
      clr      = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_acc", acc, 0);
      chk("rst_result", result, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      #2;

      // 8 x add 5 -> 40
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 5, 0);
         if (i < 7) begin
            chk("add5_done_early", done, 0);
            chk("add5_busy", busy, 1);
         end
      end
      chk("add5_done", done, 1);
      chk("add5_result", result, 40);
      chk("add5_ovf", ovf, 0);
      chk("add5_busy_after", busy, 0);
      step(0, 1, 0, 0);
      chk("add5_done_once", done, 0);
      chk("add5_result_held", result, 40);

      // first sample subtracts 3 -> underflow
      step(1, 0, 3, 0);
      chk("sub3_acc", acc, EXP_UNDER);
      chk("sub3_ovf", ovf, 1);
      chk("sub3_busy", busy, 1);
      step(0, 1, 0, 1);
      chk("clr_acc", acc, 0);
      chk("clr_ovf", ovf, 0);
      chk("clr_busy", busy, 0);
      chk("clr_result_held", result, 40);

      // 8 x 15 on 6-bit instance
      for (int i = 0; i < 8; i++) step(1, 1, 15, 0);
      chk("w6_done", done6, 1);
      chk("w6_ovf", ovf6, 1);
      chk("w6_result", result6, EXP_RES6);
      chk("w8_result", result, 120);
      chk("w8_ovf", ovf, 0);
      step(0, 1, 0, 0);

      // clr together with in_valid after 4 samples
      for (int i = 0; i < 4; i++) step(1, 1, 2, 0);
      chk("pre_clr_acc", acc, 8);
      step(1, 1, 2, 1);
      chk("clrv_acc", acc, 0);
      chk("clrv_busy", busy, 0);
      chk("clrv_done", done, 0);
      chk("clrv_result", result, 120);
      step(0, 1, 0, 0);
      chk("clrv_done_after", done, 0);

      // 16 back-to-back samples of 1
      for (int i = 0; i < 16; i++) begin
         step(1, 1, 1, 0);
         chk("b2b_acc", acc, (i % 8) + 1);
         chk("b2b_done", done, (i == 7 || i == 15) ? 1 : 0);
         chk("b2b_busy", busy, (i == 7 || i == 15) ? 0 : 1);
         if (i == 7 || i == 15) chk("b2b_result", result, 8);
      end
      step(0, 1, 0, 0);

      // async reset mid-block
      for (int i = 0; i < 3; i++) step(1, 1, 4, 0);
      chk("mid_acc", acc, 12);
      in_valid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      chk("arst_acc", acc, 0);
      chk("arst_result", result, 0);
      chk("arst_done", done, 0);
      chk("arst_ovf", ovf, 0);
      chk("arst_busy", busy, 0);
      #1;
      rst = 1'b0;
      step(1, 1, 1, 0);
      chk("fresh_acc", acc, 1);
      chk("fresh_busy", busy, 1);
      for (int i = 0; i < 7; i++) step(1, 1, 1, 0);
      chk("fresh_done", done, 1);
      chk("fresh_result", result, 8);
      step(0, 1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/addsub_acc.md
ADDSUB_ACC -- requirements
Module: addsub_acc

Interface
REQ-001 The block SHALL have parameter ACC_W, default 8, meaning accumulator/result width in bits.
REQ-002 The block SHALL have parameter BLOCK_LEN, default 8, meaning samples per accumulation block (range 2..15).
REQ-003 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the adder result on s/c_out is valid this cycle.
REQ-006 The block SHALL have port add, input, 1, meaning 1 adds the sample to acc and 0 subtracts it.
REQ-007 The block SHALL have port s, input, 3, the sum bits from the upstream 3-bit adder/subtractor.
REQ-008 The block SHALL have port c_out, input, 1, the carry from the upstream adder/subtractor.
REQ-009 The block SHALL have port clr, input, 1, synchronous block abort/clear.
REQ-010 The block SHALL have port acc, output, ACC_W, the running accumulator.
REQ-011 The block SHALL have port result, output, ACC_W, the final value of the last completed block, held.
REQ-012 The block SHALL have port done, output, 1, a one-cycle pulse when result updates.
REQ-013 The block SHALL have port ovf, output, 1, sticky per-block overflow/underflow flag.
REQ-014 The block SHALL have port busy, output, 1, high while in ACCUM state.

Function
REQ-015 The sample value SHALL be the 4-bit unsigned {c_out,s}, zero-extended to ACC_W.
REQ-016 The FSM SHALL have states IDLE, ACCUM and DONE, with all outputs registered.
REQ-017 In IDLE, in_valid SHALL load acc = 0 +/- sample, set count=1 and go to ACCUM; ovf SHALL be cleared and then set if this first op underflows.
REQ-018 In ACCUM, each in_valid SHALL update acc by add/subtract and increment count; cycles without in_valid SHALL hold all state.
REQ-019 The edge accepting sample number BLOCK_LEN SHALL load result with the final acc, assert done and enter DONE, so done is visible the cycle after the last sample edge.
REQ-020 DONE SHALL last exactly one cycle; in_valid in DONE SHALL start a new block exactly as in IDLE (no sample lost), otherwise the FSM SHALL go to IDLE.
REQ-021 Overflow (sum > 2^ACC_W-1) or underflow (difference < 0) SHALL set ovf, which stays set until the next block starts or reset.
REQ-022 clr SHALL take priority over in_valid in any state: acc=0, count=0, ovf=0, next state IDLE; result SHALL be held and done SHALL not pulse.
REQ-023 result and done SHALL be unaffected by any event except block completion and reset.

Reset
REQ-024 Asserting rst SHALL immediately force acc=0, result=0, done=0, ovf=0, busy=0, count=0 and state IDLE, including mid-block.
REQ-025 The first block after rst deassertion SHALL begin on the first in_valid sampled after deassertion.

Configuration
REQ-026 With ADDSUB_ACC_SAT_EN defined, overflow SHALL clamp acc to 2^ACC_W-1 and underflow SHALL clamp it to 0.
REQ-027 Without ADDSUB_ACC_SAT_EN, acc SHALL wrap modulo 2^ACC_W; ovf behaviour SHALL be identical in both builds.

Structure
REQ-028 The package addsub_pkg SHALL hold the FSM state typedef (IDLE/ACCUM/DONE), the sample width constant SAMPLE_W=4 and the default ACC_W/BLOCK_LEN constants.
REQ-029 The add/subtract-with-saturate datapath SHALL be a sub-module acc_alu (inputs: acc, sample, add; outputs: next_acc, ovf_evt); FSM and registers SHALL stay in addsub_acc.

Verification
REQ-030 The bench SHALL cover: 8 valid samples with add=1, {c_out,s}=4'd5 -> done pulses one cycle after the 8th edge, result=40, ovf=0, busy low afterwards.
REQ-031 The bench SHALL cover: first sample add=0, value 3 -> ovf=1; acc=0 with SAT_EN, acc=253 without.
REQ-032 The bench SHALL cover: 8 samples of 15 with ACC_W=6 -> ovf=1; result=63 with SAT_EN, 56 without.
REQ-033 The bench SHALL cover: clr asserted together with in_valid after 4 samples -> acc=0, state IDLE, no done, previous result held.
REQ-034 The bench SHALL cover: in_valid held continuously for 16 samples of value 1 -> two done pulses 8 cycles apart, result=8 both times, no dropped sample.
REQ-035 The bench SHALL cover: rst pulsed asynchronously mid-block (between clock edges) -> all outputs 0 immediately, next in_valid starts a fresh block.
